mem_ctrl: RTL

//  Memory controller downstream of the MMU. Accepts word requests from two masters (port 0 = IF,

---
 rtl/mem_ctrl_pkg.sv | 44 ++++
 rtl/mem_ctrl_rr_arbiter.sv | 47 ++++
 rtl/mem_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_ctrl_pkg
// Purpose  : Shared request codes, port indices, FSM states and slot record.
// Revision : 1.0
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [1:0] c_RW_NONE  = 2'b00;
    localparam logic [1:0] c_RW_READ  = 2'b01;
    localparam logic [1:0] c_RW_WRITE = 2'b10;

    localparam int c_IF_PORT  = 0;
    localparam int c_MEM_PORT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } mc_state_e;

    typedef struct packed {
        logic        vld;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } mc_slot_t;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] find_set_bit(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k] && (3'(k) >= from)) begin
                res = {1'b1, 2'(k)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mc_rr_arbiter
// Purpose  : Two-requester round-robin grant; favours the port not granted last.
// Revision : 1.0
// ============================================================================
module mc_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_upd_port,
    output logic       o_gnt_vld,
    output logic       o_gnt_port
);

    logic r_last_q;
    logic w_last_d;

    always_comb begin
        w_last_d = r_last_q;
        if (i_update) begin
            w_last_d = i_upd_port;
        end
    end

    // Last grant resets to port 0 so a fresh contention goes to port 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_q <= 1'b0;
        end else begin
            r_last_q <= w_last_d;
        end
    end

    always_comb begin
        o_gnt_vld  = |i_req;
        o_gnt_port = 1'b0;
        if (i_req == 2'b11) begin
            o_gnt_port = ~r_last_q;
        end else if (i_req[1]) begin
            o_gnt_port = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Serialises two-port word requests onto a byte-wide single-port RAM.
// Revision : 1.0
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_rw_flag,
    input  logic [63:0]       i_addr,
    input  logic [63:0]       i_write_data,
    input  logic [7:0]        i_write_mask,
    output logic [63:0]       o_read_data,
    output logic [1:0]        o_busy,
    output logic [1:0]        o_done,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_wr,
    output logic [7:0]        o_mem_dout,
    input  logic [7:0]        i_mem_din
);

    mc_state_e   r_state_q, w_state_d;
    mc_slot_t    r_slot_q [2];
    mc_slot_t    w_slot_d [2];
    logic        r_port_q, w_port_d;
    logic [1:0]  r_cnt_q, w_cnt_d;
    logic        r_tail_q, w_tail_d;
    logic [23:0] r_asm_q, w_asm_d;
    logic [63:0] r_rdata_q, w_rdata_d;

    logic              w_gnt_vld;
    logic              w_gnt_port;
    logic              w_arb_upd;
    logic              w_gnt_wr;
    logic [3:0]        w_gnt_mask;
    logic [31:0]       w_cur_addr;
    logic [31:0]       w_cur_data;
    logic [3:0]        w_cur_mask;
    logic [2:0]        w_first;
    logic [2:0]        w_next;
    logic [MEM_AW-1:0] w_beat_addr;

    mc_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req      ({r_slot_q[1].vld, r_slot_q[0].vld}),
        .i_update   (w_arb_upd),
        .i_upd_port (r_port_q),
        .o_gnt_vld  (w_gnt_vld),
        .o_gnt_port (w_gnt_port)
    );

    // Wrap in 32 bits first, then keep the RAM-sized low part.
    always_comb begin
        w_gnt_wr    = r_slot_q[w_gnt_port].wr;
        w_gnt_mask  = r_slot_q[w_gnt_port].mask;
        w_cur_addr  = r_slot_q[r_port_q].addr;
        w_cur_data  = r_slot_q[r_port_q].data;
        w_cur_mask  = r_slot_q[r_port_q].mask;
        w_beat_addr = MEM_AW'(w_cur_addr + 32'(r_cnt_q));
        w_first     = find_set_bit(w_gnt_mask, 3'd0);
        w_next      = find_set_bit(w_cur_mask, 3'(r_cnt_q) + 3'd1);
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_slot_d[0] = r_slot_q[0];
        w_slot_d[1] = r_slot_q[1];
        w_port_d    = r_port_q;
        w_cnt_d     = r_cnt_q;
        w_tail_d    = r_tail_q;
        w_asm_d     = r_asm_q;
        w_rdata_d   = r_rdata_q;
        w_arb_upd   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wr    = 1'b0;
        o_mem_dout  = 8'h00;
        o_done      = 2'b00;

        for (int p = 0; p < 2; p++) begin
            if (!r_slot_q[p].vld &&
                ((i_rw_flag[2*p +: 2] == c_RW_READ) || (i_rw_flag[2*p +: 2] == c_RW_WRITE))) begin
                w_slot_d[p].vld  = 1'b1;
                w_slot_d[p].wr   = (i_rw_flag[2*p +: 2] == c_RW_WRITE);
                w_slot_d[p].addr = i_addr[32*p +: 32];
                w_slot_d[p].data = i_write_data[32*p +: 32];
                w_slot_d[p].mask = i_write_mask[4*p +: 4];
            end
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_port_d = w_gnt_port;
                    w_cnt_d  = 2'd0;
                    w_tail_d = 1'b0;
                    if (!w_gnt_wr) begin
                        w_state_d = ST_RD;
                    end else if (w_first[2]) begin
                        w_state_d = ST_WR;
                        w_cnt_d   = w_first[1:0];
                    end else begin
                        w_state_d = ST_DONE;
                    end
                end
            end

            ST_RD: begin
                if (!r_tail_q) begin
                    o_mem_addr = w_beat_addr;
                    // RAM data lags its address by one cycle: this beat collects byte cnt-1.
                    case (r_cnt_q)
                        2'd1:    w_asm_d[7:0]   = i_mem_din;
                        2'd2:    w_asm_d[15:8]  = i_mem_din;
                        2'd3:    w_asm_d[23:16] = i_mem_din;
                        default: w_asm_d        = r_asm_q;
                    endcase
                    if (r_cnt_q == 2'd3) begin
                        w_tail_d = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt_q + 2'd1;
                    end
                end else begin
                    if (r_port_q) begin
                        w_rdata_d[63:32] = {i_mem_din, r_asm_q};
                    end else begin
                        w_rdata_d[31:0]  = {i_mem_din, r_asm_q};
                    end
                    w_tail_d  = 1'b0;
                    w_cnt_d   = 2'd0;
                    w_state_d = ST_DONE;
                end
            end

            ST_WR: begin
                o_mem_wr   = 1'b1;
                o_mem_addr = w_beat_addr;
                o_mem_dout = w_cur_data[{r_cnt_q, 3'b000} +: 8];
                if (w_next[2]) begin
                    w_cnt_d = w_next[1:0];
                end else begin
                    w_cnt_d   = 2'd0;
                    w_state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                o_done[r_port_q]   = 1'b1;
                w_slot_d[r_port_q] = '0;
                w_arb_upd          = 1'b1;
                w_state_d          = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q   <= ST_IDLE;
            r_slot_q[0] <= '0;
            r_slot_q[1] <= '0;
            r_port_q    <= 1'b0;
            r_cnt_q     <= 2'd0;
            r_tail_q    <= 1'b0;
            r_asm_q     <= 24'h0;
            r_rdata_q   <= 64'h0;
        end else begin
            r_state_q   <= w_state_d;
            r_slot_q[0] <= w_slot_d[0];
            r_slot_q[1] <= w_slot_d[1];
            r_port_q    <= w_port_d;
            r_cnt_q     <= w_cnt_d;
            r_tail_q    <= w_tail_d;
            r_asm_q     <= w_asm_d;
            r_rdata_q   <= w_rdata_d;
        end
    end

    assign o_busy      = {r_slot_q[1].vld, r_slot_q[0].vld};
    assign o_read_data = r_rdata_q;

endmodule
`default_nettype wire
